// File: rtl/axil_slave_bridge.sv
// AXI4-Lite slave that turns each read/write into a one-cycle backend request and returns the completion.
// Optional completion timeout: define AXIL_SLAVE_TIMEOUT_EN.
module axil_slave_bridge #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                axi_aclk,
  input  logic                axi_areset,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  output logic [1:0]          axi_bresp,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  input  logic [ADDR_W-1:0]   axi_araddr,
  output logic                axi_rvalid,
  input  logic                axi_rready,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                bk_wstart,
  output logic [ADDR_W-1:0]   bk_waddr,
  output logic [DATA_W-1:0]   bk_wdata,
  output logic [DATA_W/8-1:0] bk_wstrb,
  input  logic                bk_wdone,
  input  logic                bk_werr,
  output logic                bk_rstart,
  output logic [ADDR_W-1:0]   bk_raddr,
  input  logic [DATA_W-1:0]   bk_rdata,
  input  logic                bk_rdone,
  input  logic                bk_rerr
);
  if (!(DATA_W == 32 || DATA_W == 64) || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("axil_slave_bridge: DATA_W must be 32 or 64 and TIMEOUT 1..65535");
  end

  typedef enum logic [1:0] {W_IDLE, W_BK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_BK, R_RESP} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic     live;
  logic     aw_got, w_got, w_first, w_err;
  logic     r_first, r_err;
  logic     aw_hs, w_hs, ar_hs;
  logic     w_timeout, r_timeout;

  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid && axi_wready;
  assign ar_hs = axi_arvalid && axi_arready;

  // Readies are gated by this flag so they stay low throughout reset and rise one cycle after it.
  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) live <= 1'b0;
    else            live <= 1'b1;
  end

  // ---------------- write path ----------------
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) w_state <= W_IDLE;
    else            w_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if ((aw_got || aw_hs) && (w_got || w_hs)) w_next = W_BK;
      W_BK:    if (bk_wdone || w_timeout) w_next = W_RESP;
      W_RESP:  if (axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    bk_wstart   = 1'b0;
    case (w_state)
      W_IDLE: begin
        axi_awready = live && !aw_got;
        axi_wready  = live && !w_got;
      end
      W_BK:    bk_wstart  = w_first;
      W_RESP:  axi_bvalid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      w_first  <= 1'b0;
      w_err    <= 1'b0;
      bk_waddr <= '0;
      bk_wdata <= '0;
      bk_wstrb <= '0;
    end else begin
      w_first <= (w_state == W_IDLE) && (w_next == W_BK);
      if ((w_state == W_IDLE) && (w_next == W_BK)) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (aw_hs) bk_waddr <= axi_awaddr;
      if (w_hs) begin
        bk_wdata <= axi_wdata;
        bk_wstrb <= axi_wstrb;
      end
      // Leaving W_BK without a done can only be a timeout, which reports SLVERR.
      if ((w_state == W_BK) && (w_next == W_RESP)) w_err <= bk_wdone ? bk_werr : 1'b1;
    end
  end

  assign axi_bresp = {w_err, 1'b0};

  // ---------------- read path ----------------
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) r_state <= R_IDLE;
    else            r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_BK;
      R_BK:    if (bk_rdone || r_timeout) r_next = R_RESP;
      R_RESP:  if (axi_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    bk_rstart   = 1'b0;
    case (r_state)
      R_IDLE:  axi_arready = live;
      R_BK:    bk_rstart   = r_first;
      R_RESP:  axi_rvalid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_first   <= 1'b0;
      r_err     <= 1'b0;
      bk_raddr  <= '0;
      axi_rdata <= '0;
    end else begin
      r_first <= (r_state == R_IDLE) && (r_next == R_BK);
      if (ar_hs) bk_raddr <= axi_araddr;
      if ((r_state == R_BK) && (r_next == R_RESP)) begin
        r_err     <= bk_rdone ? bk_rerr : 1'b1;
        axi_rdata <= bk_rdone ? bk_rdata : '0;
      end
    end
  end

  assign axi_rresp = {r_err, 1'b0};

  // ---------------- completion timeout ----------------
`ifdef AXIL_SLAVE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  logic [15:0] w_cnt, r_cnt;

  // Counters sit at zero outside the backend state, so they read zero in the start cycle.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset || (w_state != W_BK)) w_cnt <= '0;
    else if (!bk_wdone)                  w_cnt <= w_cnt + 16'd1;
    if (axi_areset || (r_state != R_BK)) r_cnt <= '0;
    else if (!bk_rdone)                  r_cnt <= r_cnt + 16'd1;
  end

  assign w_timeout = (w_state == W_BK) && (w_cnt == TIMEOUT_CNT);
  assign r_timeout = (r_state == R_BK) && (r_cnt == TIMEOUT_CNT);
`else
  assign w_timeout = 1'b0;
  assign r_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axil_slave_bridge.sv
// Scoreboard bench for axil_slave_bridge: expectations are queued with the stimulus and popped by output monitors.
module tb_axil_slave_bridge;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
  logic [DATA_W-1:0] wdata = '0, bk_rdata = '0;
  logic [STRB_W-1:0] wstrb = '0;
  logic              bk_wdone = 1'b0, bk_werr = 1'b0, bk_rdone = 1'b0, bk_rerr = 1'b0;
  logic              awready, wready, bvalid, arready, rvalid, bk_wstart, bk_rstart;
  logic [1:0]        bresp, rresp;
  logic [DATA_W-1:0] rdata, bk_wdata;
  logic [ADDR_W-1:0] bk_waddr, bk_raddr;
  logic [STRB_W-1:0] bk_wstrb;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wreq_t;
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
  } rrsp_t;

  wreq_t             exp_wreq[$];
  logic [ADDR_W-1:0] exp_rreq[$];
  logic [1:0]        exp_b[$];
  rrsp_t             exp_r[$];
  int                checks = 0, errors = 0, wstart_seen = 0;

  always #5 clk = ~clk;

  axil_slave_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr),
    .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
    .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp),
    .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr),
    .axi_rvalid(rvalid), .axi_rready(rready), .axi_rdata(rdata), .axi_rresp(rresp),
    .bk_wstart(bk_wstart), .bk_waddr(bk_waddr), .bk_wdata(bk_wdata), .bk_wstrb(bk_wstrb),
    .bk_wdone(bk_wdone), .bk_werr(bk_werr),
    .bk_rstart(bk_rstart), .bk_raddr(bk_raddr), .bk_rdata(bk_rdata),
    .bk_rdone(bk_rdone), .bk_rerr(bk_rerr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {awready, wready, bvalid, bresp, arready, rvalid, rresp, bk_wstart, bk_rstart}, '0);
    check({tag, "_rdata"}, rdata, '0);
    check({tag, "_bk_addr"}, {bk_waddr, bk_raddr, bk_wstrb}, '0);
    check({tag, "_bk_wdata"}, bk_wdata, '0);
  endtask

  // Output monitors: each DUT event pops the oldest expectation for its channel.
  always @(negedge clk) begin : mon_w
    wreq_t e;
    if (!rst && bk_wstart) begin
      wstart_seen++;
      if (exp_wreq.size() == 0) check("wstart_unexpected", bk_wstart, 1'b0);
      else begin
        e = exp_wreq.pop_front();
        check("bk_waddr", bk_waddr, e.addr);
        check("bk_wdata", bk_wdata, e.data);
        check("bk_wstrb", bk_wstrb, e.strb);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [1:0] e;
    if (!rst && bvalid && bready) begin
      if (exp_b.size() == 0) check("bvalid_unexpected", bvalid, 1'b0);
      else begin
        e = exp_b.pop_front();
        check("bresp", bresp, e);
      end
    end
  end

  always @(negedge clk) begin : mon_ar
    logic [ADDR_W-1:0] e;
    if (!rst && bk_rstart) begin
      if (exp_rreq.size() == 0) check("rstart_unexpected", bk_rstart, 1'b0);
      else begin
        e = exp_rreq.pop_front();
        check("bk_raddr", bk_raddr, e);
      end
    end
  end

  always @(negedge clk) begin : mon_r
    rrsp_t e;
    if (!rst && rvalid && rready) begin
      if (exp_r.size() == 0) check("rvalid_unexpected", rvalid, 1'b0);
      else begin
        e = exp_r.pop_front();
        check("rdata", rdata, e.data);
        check("rresp", rresp, e.resp);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: everything low, readies rise one cycle after release.
    step(); step(); step();
    @(negedge clk); check_zero("reset");
    step(); rst = 1'b0;
    @(negedge clk); check("ready_before_edge", {awready, wready, arready}, 3'b000);
    step();
    @(negedge clk); check("ready_after_reset", {awready, wready, arready}, 3'b111);

    // AW before W, done three cycles after the start pulse.
    bready = 1'b1;
    step(); awvalid = 1'b1; awaddr = 12'h010;
    step(); awvalid = 1'b0;
    @(negedge clk); check("aw_ready_drop", {awready, wready}, 2'b01);
    step(); wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF;
    exp_wreq.push_back('{12'h010, 32'h1234_5678, 4'hF});
    exp_b.push_back(2'b00);
    step(); wvalid = 1'b0;
    @(negedge clk); check("wstart_latency", bk_wstart, 1'b1);
    step(); step(); step(); bk_wdone = 1'b1;
    step(); bk_wdone = 1'b0;
    @(negedge clk); check("b_latency", bvalid, 1'b1);
    step();
    @(negedge clk); check("b_drop", bvalid, 1'b0);
    check("wstart_count", wstart_seen, 1);
    check("w_ready_back", {awready, wready}, 2'b11);

    // Simultaneous AW/W, done in the start cycle, bready held off for four cycles.
    bready = 1'b0;
    step(); awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h020; wdata = 32'hCAFE_0001; wstrb = 4'h3;
    exp_wreq.push_back('{12'h020, 32'hCAFE_0001, 4'h3});
    exp_b.push_back(2'b00);
    step(); awvalid = 1'b0; wvalid = 1'b0; bk_wdone = 1'b1;
    @(negedge clk); check("wstart_same_cycle", bk_wstart, 1'b1);
    step(); bk_wdone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("b_hold", {bvalid, bresp}, 3'b100);
      if (i < 3) step();
    end
    step(); bready = 1'b1;
    step(); bready = 1'b0;
    @(negedge clk); check("b_drop_after_ready", bvalid, 1'b0);

    // Read OKAY with delayed rready; backend data changes after the done.
    step(); arvalid = 1'b1; araddr = 12'h044;
    exp_rreq.push_back(12'h044);
    exp_r.push_back('{32'hDEAD_BEEF, 2'b00});
    step(); arvalid = 1'b0;
    @(negedge clk); check("rstart_latency", {bk_rstart, arready}, 2'b10);
    step(); step(); bk_rdone = 1'b1; bk_rdata = 32'hDEAD_BEEF;
    step(); bk_rdone = 1'b0; bk_rdata = 32'h0BAD_F00D;
    @(negedge clk); check("r_latency", {rvalid, arready}, 2'b10);
    step();
    @(negedge clk); check("rdata_stable", rdata, 32'hDEAD_BEEF);
    step(); rready = 1'b1;
    step(); rready = 1'b0;
    @(negedge clk); check("r_drop", {rvalid, arready}, 2'b01);

    // Stray done while idle is ignored; then an error read completing in its start cycle.
    step(); bk_rdone = 1'b1; bk_rdata = 32'h1111_1111;
    step(); bk_rdone = 1'b0;
    @(negedge clk); check("stray_rdone", rvalid, 1'b0);
    rready = 1'b1;
    step(); arvalid = 1'b1; araddr = 12'h0F8;
    exp_rreq.push_back(12'h0F8);
    exp_r.push_back('{32'h5555_AAAA, 2'b10});
    step(); arvalid = 1'b0; bk_rdone = 1'b1; bk_rerr = 1'b1; bk_rdata = 32'h5555_AAAA;
    step(); bk_rdone = 1'b0; bk_rerr = 1'b0;
    @(negedge clk); check("rresp_err", {rvalid, rresp}, 3'b110);

    // Concurrent read and write, zero strobes, write error.
    bready = 1'b1;
    step(); awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    awaddr = 12'h100; wdata = 32'h89AB_CDEF; wstrb = 4'h0; araddr = 12'h200;
    exp_wreq.push_back('{12'h100, 32'h89AB_CDEF, 4'h0});
    exp_rreq.push_back(12'h200);
    exp_b.push_back(2'b10);
    exp_r.push_back('{32'h1357_9BDF, 2'b00});
    step(); awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk); check("concurrent_start", {bk_wstart, bk_rstart}, 2'b11);
    step(); bk_rdone = 1'b1; bk_rdata = 32'h1357_9BDF;
    step(); bk_rdone = 1'b0; bk_wdone = 1'b1; bk_werr = 1'b1;
    step(); bk_wdone = 1'b0; bk_werr = 1'b0;
    step(); step();
    @(negedge clk); check("concurrent_idle", {awready, wready, arready, bvalid, rvalid}, 5'b11100);

    // Reset while waiting in the backend state.
    step(); awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h300; wdata = 32'h0102_0304; wstrb = 4'hF;
    exp_wreq.push_back('{12'h300, 32'h0102_0304, 4'hF});
    step(); awvalid = 1'b0; wvalid = 1'b0;
    step(); rst = 1'b1;
    step();
    @(negedge clk); check_zero("mid_reset");
    step(); rst = 1'b0; bk_wdone = 1'b1;
    step(); bk_wdone = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("no_b_after_reset", {bvalid, bk_wstart}, 2'b00);
      step();
    end
    @(negedge clk); check("ready_after_mid_reset", {awready, wready, arready}, 3'b111);

`ifdef AXIL_SLAVE_TIMEOUT_EN
    // Timeout: no done, SLVERR response in cycle 9 after the start pulse; late done ignored.
    bready = 1'b0;
    step(); awvalid = 1'b1; wvalid = 1'b1; awaddr = 12'h400; wdata = 32'h0000_0077; wstrb = 4'h1;
    exp_wreq.push_back('{12'h400, 32'h0000_0077, 4'h1});
    exp_b.push_back(2'b10);
    step(); awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk); check("to_wstart", bk_wstart, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); check("to_wait", bvalid, 1'b0);
    end
    @(negedge clk); check("to_bvalid", {bvalid, bresp}, 3'b110);
    step(); bk_wdone = 1'b1;
    step(); bk_wdone = 1'b0;
    @(negedge clk); check("to_late_done", {bvalid, bresp}, 3'b110);
    step(); bready = 1'b1;
    step(); bready = 1'b0;
    @(negedge clk); check("to_b_drop", bvalid, 1'b0);
`endif

    step(); step();
    check("wreq_left", exp_wreq.size(), 0);
    check("rreq_left", exp_rreq.size(), 0);
    check("b_left", exp_b.size(), 0);
    check("r_left", exp_r.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axil_slave_bridge.md
# axil_slave_bridge

Parametrised AXI4-Lite slave that converts AXI-Lite read and write transactions into single-pulse backend requests, and returns completion to the master. It is the next generation of the team's AXI-Lite frontend:
- address and data widths are configurable;
- the write-response (B) channel and RRESP are implemented in full;
- AW and W are accepted in any order;
- backend error reporting and an optional completion timeout are added.

Read and write paths are fully independent, each with one outstanding transaction.

## Interface
Parameters:
- ADDR_W, 12, AXI and backend address width
- DATA_W, 32, data width; must be 32 or 64; strobe width is DATA_W/8
- TIMEOUT, 255, backend completion timeout in cycles (1..65535); used only with AXIL_SLAVE_TIMEOUT_EN

Ports:
- axi_aclk  in  1  single clock; all logic on rising edge
- axi_areset  in  1  reset, synchronous, active-high
- axi_awvalid / axi_awready  in / out  1  write-address handshake
- axi_awaddr  in  ADDR_W  write address
- axi_wvalid / axi_wready  in / out  1  write-data handshake
- axi_wdata  in  DATA_W  write data
- axi_wstrb  in  DATA_W/8  byte strobes
- axi_bvalid / axi_bready  out / in  1  write-response handshake
- axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- axi_arvalid / axi_arready  in / out  1  read-address handshake
- axi_araddr  in  ADDR_W  read address
- axi_rvalid / axi_rready  out / in  1  read-data handshake
- axi_rdata  out  DATA_W  read data
- axi_rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- bk_wstart  out  1  one-cycle write request pulse
- bk_waddr, bk_wdata, bk_wstrb  out  ADDR_W, DATA_W, DATA_W/8  write request payload
- bk_wdone  in  1  write completion pulse
- bk_werr  in  1  write error; sampled with bk_wdone
- bk_rstart  out  1  one-cycle read request pulse
- bk_raddr  out  ADDR_W  read address
- bk_rdata  in  DATA_W  read data; sampled with bk_rdone
- bk_rdone  in  1  read completion pulse
- bk_rerr  in  1  read error; sampled with bk_rdone

## Operation
Write FSM states: W_IDLE, W_BK, W_RESP.
- **W_IDLE**
  - axi_awready=1 until AW is captured; axi_wready=1 until W is captured.
  - Each channel is captured on its own handshake, in either order or in the same cycle.
  - A captured channel drops its ready until the transaction ends.
  - When both are captured, go to W_BK.
- **W_BK**
  - bk_wstart=1 in the first cycle only.
  - bk_waddr, bk_wdata and bk_wstrb hold the captured values for the whole state.
  - On bk_wdone, latch bk_werr and go to W_RESP.
- **W_RESP**
  - axi_bvalid=1; axi_bresp = latched error ? 2'b10 : 2'b00.
  - On axi_bready, return to W_IDLE.

Read FSM states: R_IDLE, R_BK, R_RESP.
- **R_IDLE**: axi_arready=1. On the handshake, capture axi_araddr and go to R_BK.
- **R_BK**
  - bk_rstart=1 in the first cycle only; bk_raddr is held for the whole state.
  - On bk_rdone, latch bk_rdata and bk_rerr, then go to R_RESP.
- **R_RESP**
  - axi_rvalid=1 with the latched data; axi_rresp = err ? 2'b10 : 2'b00.
  - On axi_rready, return to R_IDLE.

General rules:
- bk_wdone / bk_rdone arriving outside W_BK / R_BK are ignored.
- Completion is accepted in any W_BK / R_BK cycle, including the bk_*start cycle.
- On an error, axi_rdata carries bk_rdata unchanged.
- A wstrb of all zeros is forwarded as-is.
- Read and write paths never block each other. Simultaneous backend start pulses are legal.

## Timing
- **Reset values:** every output is 0 while axi_areset=1, including all ready signals. Readies rise in the first cycle after reset deasserts.
- **Reset mid-transaction:**
  - The transaction is abandoned with no further bk_* pulse and no response.
  - Valids drop in the cycle after the reset edge.
- **Write latency**
  - The last of the AW/W handshakes occurs at edge N; bk_wstart is high during cycle N+1.
  - bk_wdone at edge M gives axi_bvalid high from cycle M+1.
  - Minimum: AW/W handshake to bvalid = 2 cycles.
- **Read latency**
  - AR handshake at edge N gives bk_rstart in cycle N+1.
  - bk_rdone at edge M gives axi_rvalid from cycle M+1.
- **Response stability:** bvalid/bresp and rvalid/rdata/rresp are registered and stay stable until their handshake completes.
- **Back-to-back:** a new address is accepted the cycle after the B/R handshake. There is no combinational path from any input to any ready signal.

## Configuration
- Macro: AXIL_SLAVE_TIMEOUT_EN.
- **Defined**
  - A per-path counter clears on bk_*start and increments in each W_BK/R_BK cycle without a done.
  - When the counter reaches TIMEOUT, the path enters *_RESP with resp=2'b10; read data is 0.
  - Late done pulses are ignored.
- **Undefined**
  - No counters are built; W_BK/R_BK wait indefinitely.
  - bk_werr/bk_rerr still produce SLVERR.

## Test plan
- **AW before W:** AW 0x010 handshakes, then W 0x12345678 / wstrb 0xF two cycles later; bk_wdone arrives 3 cycles after bk_wstart with bready=1.
  - Expect exactly one bk_wstart with waddr 0x010 and wdata 0x12345678.
  - Expect bvalid one cycle after done, bresp=00.
- **Simultaneous AW/W, delayed bready:** AW/W in the same cycle with wstrb 0x3; bready held 0 for 4 cycles.
  - Expect bvalid and bresp=00 stable for those 4 cycles, then drop the cycle after bready.
- **Read OKAY:** araddr 0x044; bk_rdone with bk_rdata 0xDEADBEEF two cycles after bk_rstart.
  - Expect rvalid with rdata 0xDEADBEEF, rresp=00.
  - Expect arready=0 until the R handshake completes.
- **Read error:** bk_rerr=1 with bk_rdone.
  - Expect rresp=10.
- **Timeout** (macro on, TIMEOUT=8): no bk_wdone.
  - Expect bvalid with bresp=10 in cycle 9 after bk_wstart.
  - A bk_wdone injected afterwards has no effect.
- **Concurrency and reset:** read and write are issued concurrently with overlapping backend pulses, and both complete independently. A reset asserted during W_BK gives all outputs 0 and no bvalid.
